// File: rtl/nes_dma_pkg.sv
// Shared constants and FSM state encoding for the NES sprite OAM DMA engine.
package nes_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDRESS = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDRESS = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/cpu_cycle_parity.sv
// Get/put cycle tracker: toggles on every CPU clock-enable cycle, cleared by reset.
module cpu_cycle_parity (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clk_en,
  output logic o_odd
);

  logic odd_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      odd_q <= 1'b0;
    end else if (i_clk_en) begin
      odd_q <= ~odd_q;
    end
  end

  assign o_odd = odd_q;

endmodule

// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA: a CPU write to $4014 halts the CPU and copies page $XX00-$XXFF to OAMDATA.
// Optional macro OAM_DMA_PARITY_ALIGN_EN adds the odd-cycle ALIGN dummy cycle.
//
// state | meaning
// IDLE  | CPU owns the bus, waiting for a write to the DMA register
// HALT  | CPU stalled, waiting for it to reach a read cycle
// ALIGN | one dummy read cycle to land the copy on a get cycle
// READ  | read byte {page,count} into the latch
// WRITE | write the latch to OAMDATA, advance count
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDRESS = nes_dma_pkg::DMA_REG_ADDRESS,
  parameter logic [15:0] OAMDATA_ADDRESS = nes_dma_pkg::OAMDATA_ADDRESS,
  parameter int unsigned NUM_BYTES       = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [15:0] i_address_cpu,
  input  logic        i_rw_cpu,
  input  logic [7:0]  i_data_cpu,
  output logic        o_cpu_halt,
  output logic        o_bus_master,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  output logic        o_busy
);

  import nes_dma_pkg::*;

  localparam logic [7:0] LAST_COUNT = 8'(NUM_BYTES - 1);

  dma_state_e  state_q;
  logic [7:0]  page_q;
  logic [7:0]  count_q;
  logic [7:0]  latch_q;
  logic        halt_q;
  logic        master_q;
  logic        busy_q;
  logic        rw_q;
  logic [15:0] addr_q;
  logic        align_req;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic odd;

  cpu_cycle_parity u_parity (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clk_en (i_clk_en),
    .o_odd    (odd)
  );

  assign align_req = odd;
`else
  assign align_req = 1'b0;
`endif

  // Outputs are registered alongside the state, so each transition loads the
  // bus values the next state presents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      count_q  <= 8'h00;
      latch_q  <= 8'h00;
      halt_q   <= 1'b0;
      master_q <= 1'b0;
      busy_q   <= 1'b0;
      rw_q     <= RW_READ;
      addr_q   <= 16'h0000;
    end else if (i_clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_address_cpu == DMA_REG_ADDRESS && i_rw_cpu == RW_WRITE) begin
            state_q <= ST_HALT;
            page_q  <= i_data_cpu;
            count_q <= 8'h00;
            halt_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_HALT: begin
          // The CPU may only be stopped on a read, so a pending write finishes first.
          if (i_rw_cpu == RW_READ) begin
            master_q <= 1'b1;
            rw_q     <= RW_READ;
            if (align_req) begin
              state_q <= ST_ALIGN;
              addr_q  <= OAMDATA_ADDRESS;
            end else begin
              state_q <= ST_READ;
              addr_q  <= {page_q, count_q};
            end
          end
        end
        ST_ALIGN: begin
          state_q <= ST_READ;
          rw_q    <= RW_READ;
          addr_q  <= {page_q, count_q};
        end
        ST_READ: begin
          state_q <= ST_WRITE;
          latch_q <= i_data;
          rw_q    <= RW_WRITE;
          addr_q  <= OAMDATA_ADDRESS;
        end
        ST_WRITE: begin
          count_q <= count_q + 8'd1;
          latch_q <= 8'h00;
          rw_q    <= RW_READ;
          if (count_q == LAST_COUNT) begin
            state_q  <= ST_IDLE;
            halt_q   <= 1'b0;
            master_q <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= 16'h0000;
          end else begin
            state_q <= ST_READ;
            addr_q  <= {page_q, count_q + 8'd1};
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          halt_q   <= 1'b0;
          master_q <= 1'b0;
          busy_q   <= 1'b0;
          rw_q     <= RW_READ;
          addr_q   <= 16'h0000;
          latch_q  <= 8'h00;
        end
      endcase
    end
  end

  assign o_cpu_halt   = halt_q;
  assign o_bus_master = master_q;
  assign o_busy       = busy_q;
  assign o_rw         = rw_q;
  assign o_address    = addr_q;
  assign o_data       = latch_q;

endmodule
